// File: rtl/mesm6_alu_seq.sv
// Sequences one accumulator operation at a time through a registered multi-cycle ALU.
// Response arrives N+2 cycles after accept, or TIMEOUT+1 cycles with rsp_err; req_ready is high only in IDLE.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 6
`endif
`ifndef ALU_NOP
`define ALU_NOP 6'd0
`endif
`ifndef ALU_AND
`define ALU_AND 6'd3
`endif
`ifndef ALU_ADD_CARRY_AROUND
`define ALU_ADD_CARRY_AROUND 6'd12
`endif

module mesm6_alu_seq #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [`ALU_OP_WIDTH-1:0] req_op,
  input  logic [47:0]              req_operand,
  input  logic                     req_wy,
  output logic [`ALU_OP_WIDTH-1:0] alu_op,
  output logic                     alu_wy,
  output logic [47:0]              alu_a,
  output logic [47:0]              alu_b,
  input  logic [47:0]              alu_result,
  input  logic [47:0]              alu_y,
  input  logic                     alu_done,
  output logic [47:0]              acc,
  output logic [47:0]              yreg,
  output logic                     rsp_valid,
  output logic                     rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, SHORT} state_t;

  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  state_t                   state, state_nxt;
  logic [`ALU_OP_WIDTH-1:0] op_q;
  logic [3:0]               timer;
  logic                     err_q;
  logic                     wy_q;
  logic                     accept;
  logic                     req_is_nop;
  logic                     timeout_hit;

  assign accept      = req_valid & req_ready;
  assign req_is_nop  = (req_op == `ALU_NOP);
  assign timeout_hit = (timer == TMO_LAST);
  assign alu_a       = acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_is_nop ? SHORT : ISSUE;
      ISSUE:   if (alu_done || timeout_hit) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      SHORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs depend on registered state only, so no request or ALU input reaches them combinationally.
  always_comb begin
    req_ready = (state == IDLE);
    alu_op    = (state == ISSUE) ? op_q : `ALU_NOP;
    alu_wy    = (state == SHORT) & wy_q;
    rsp_valid = (state == RELEASE) | (state == SHORT);
    rsp_err   = (state == RELEASE) & err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= `ALU_NOP;
      alu_b <= '0;
      acc   <= '0;
      yreg  <= '0;
      timer <= '0;
      err_q <= 1'b0;
      wy_q  <= 1'b0;
    end else begin
      if (accept) begin
        timer <= '0;
        err_q <= 1'b0;
        wy_q  <= req_is_nop & req_wy;
        if (!req_is_nop) begin
          op_q  <= req_op;
          alu_b <= req_operand;
        end else if (!req_wy) begin
          acc <= req_operand;
        end
      end
      if (state == ISSUE) begin
        timer <= timer + 4'd1;
        if (alu_done) begin
          acc  <= alu_result;
          yreg <= alu_y;
        end else if (timeout_hit) begin
          err_q <= 1'b1;
        end
      end
      if (state == SHORT && wy_q) yreg <= acc;
    end
  end

endmodule

// File: tb/tb_mesm6_alu_seq.sv
// Directed bench for mesm6_alu_seq with a registered ALU model of programmable latency.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 6
`endif
`ifndef ALU_NOP
`define ALU_NOP 6'd0
`endif
`ifndef ALU_AND
`define ALU_AND 6'd3
`endif
`ifndef ALU_ADD_CARRY_AROUND
`define ALU_ADD_CARRY_AROUND 6'd12
`endif

module tb_mesm6_alu_seq;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     req_valid = 1'b0;
  logic                     req_ready;
  logic [`ALU_OP_WIDTH-1:0] req_op = `ALU_NOP;
  logic [47:0]              req_operand = '0;
  logic                     req_wy = 1'b0;
  logic [`ALU_OP_WIDTH-1:0] alu_op;
  logic                     alu_wy;
  logic [47:0]              alu_a, alu_b;
  logic [47:0]              alu_result = '0;
  logic [47:0]              alu_y = '0;
  logic                     alu_done = 1'b0;
  logic [47:0]              acc, yreg;
  logic                     rsp_valid, rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  int   alu_lat = 1;
  int   alu_cnt = 0;
  int   rsp_cyc;
  logic rsp_err_s;
  logic op_nop_at_rsp;
  logic ready_after;
  int   wy_cnt, wy_rsp_cnt;
  logic a_mismatch;

  mesm6_alu_seq #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_operand(req_operand), .req_wy(req_wy),
    .alu_op(alu_op), .alu_wy(alu_wy), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_y(alu_y), .alu_done(alu_done),
    .acc(acc), .yreg(yreg), .rsp_valid(rsp_valid), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] alu_f(input logic [`ALU_OP_WIDTH-1:0] op,
                                        input logic [47:0] a, input logic [47:0] b);
    logic [48:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      `ALU_AND:              return a & b;
      `ALU_ADD_CARRY_AROUND: return s[47:0] + {47'd0, s[48]};
      default:               return '0;
    endcase
  endfunction

  // ALU model: done after alu_lat non-NOP cycles (0 = never), cleared only by a NOP.
  always @(posedge clk) begin
    if (alu_op == `ALU_NOP) begin
      alu_done <= 1'b0;
      alu_cnt  <= 0;
    end else begin
      alu_cnt <= alu_cnt + 1;
      if (alu_lat != 0 && alu_cnt + 1 == alu_lat) begin
        alu_done   <= 1'b1;
        alu_result <= alu_f(alu_op, alu_a, alu_b);
        alu_y      <= ~alu_f(alu_op, alu_a, alu_b);
      end
    end
  end

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accept edge is cycle 0; cycle k is sampled on the falling edge after edge k-1.
  task automatic run_op(input logic [`ALU_OP_WIDTH-1:0] op, input logic [47:0] operand,
                        input logic wy, input int lat);
    alu_lat = lat;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_operand = operand; req_wy = wy;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rsp_cyc = -1; rsp_err_s = 1'bx; op_nop_at_rsp = 1'b0; ready_after = 1'b0;
    wy_cnt = 0; wy_rsp_cnt = 0; a_mismatch = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (alu_a !== acc) a_mismatch = 1'b1;
      if (alu_wy) wy_cnt++;
      if (alu_wy && rsp_valid) wy_rsp_cnt++;
      if (rsp_valid) begin
        rsp_cyc       = i;
        rsp_err_s     = rsp_err;
        op_nop_at_rsp = (alu_op == `ALU_NOP);
        @(negedge clk);
        ready_after   = req_ready;
        break;
      end
    end
  endtask

  logic [9:0] ready_v, busy_v;
  int         spurious;

  initial begin
    #3;
    chk("rst_alu_op", 48'(alu_op), 48'(`ALU_NOP));
    chk("rst_acc", acc, 48'h0);
    chk("rst_yreg", yreg, 48'h0);
    chk("rst_alu_b", alu_b, 48'h0);
    chk("rst_rsp", {46'd0, rsp_valid, rsp_err}, 48'h0);
    chk("rst_wy", 48'(alu_wy), 48'h0);
    #4 reset = 1'b0;
    #1 chk("rst_ready", 48'(req_ready), 48'h1);

    run_op(`ALU_NOP, 48'hFFFF00FF00FF, 1'b0, 1);
    chk("load_cyc", 48'(rsp_cyc), 48'd1);
    chk("load_acc", acc, 48'hFFFF00FF00FF);

    run_op(`ALU_AND, 48'h0F0F0F0F0F0F, 1'b0, 1);
    chk("and_cyc", 48'(rsp_cyc), 48'd3);
    chk("and_err", 48'(rsp_err_s), 48'h0);
    chk("and_ready_c4", 48'(ready_after), 48'h1);
    chk("and_acc", acc, 48'h0F0F000F000F);
    chk("and_yreg", yreg, 48'hF0F0FFF0FFF0);
    chk("and_alu_b", alu_b, 48'h0F0F0F0F0F0F);
    chk("and_alu_a", 48'(a_mismatch), 48'h0);

    run_op(`ALU_NOP, 48'h800000000000, 1'b0, 1);
    run_op(`ALU_ADD_CARRY_AROUND, 48'h800000000001, 1'b0, 2);
    chk("aca_cyc", 48'(rsp_cyc), 48'd4);
    chk("aca_nop", 48'(op_nop_at_rsp), 48'h1);
    chk("aca_acc", acc, 48'h000000000002);

    run_op(`ALU_AND, 48'h0, 1'b0, 0);
    chk("tmo_cyc", 48'(rsp_cyc), 48'd16);
    chk("tmo_err", 48'(rsp_err_s), 48'h1);
    chk("tmo_nop", 48'(op_nop_at_rsp), 48'h1);
    chk("tmo_acc", acc, 48'h000000000002);
    chk("tmo_yreg", yreg, 48'hFFFFFFFFFFFD);

    run_op(`ALU_NOP, 48'h123456789ABC, 1'b0, 1);
    run_op(`ALU_NOP, 48'h0, 1'b1, 1);
    chk("wy_cyc", 48'(rsp_cyc), 48'd1);
    chk("wy_cnt", 48'(wy_cnt), 48'd1);
    chk("wy_with_rsp", 48'(wy_rsp_cnt), 48'd1);
    chk("wy_yreg", yreg, 48'h123456789ABC);
    chk("wy_acc", acc, 48'h123456789ABC);

    // Back-to-back: req_valid held high across two and a half operations.
    alu_lat = 1;
    @(negedge clk);
    req_valid = 1'b1; req_op = `ALU_AND; req_operand = 48'h0000FFFFFFFF; req_wy = 1'b0;
    for (int j = 0; j < 10; j++) begin
      ready_v[j] = req_ready;
      busy_v[j]  = (alu_op != `ALU_NOP);
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    @(negedge clk);
    chk("b2b_ready", 48'(ready_v), 48'h111);
    chk("b2b_busy", 48'(busy_v), 48'h266);
    chk("b2b_acc", acc, 48'h000056789ABC);
    chk("b2b_idle", 48'(req_ready), 48'h1);

    // Reset pulse in the middle of ISSUE.
    alu_lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = `ALU_AND; req_operand = 48'h1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 48'(alu_op), 48'(`ALU_AND));
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_op", 48'(alu_op), 48'(`ALU_NOP));
    chk("mid_rst_acc", acc, 48'h0);
    chk("mid_rst_rsp", 48'(rsp_valid), 48'h0);
    #1 reset = 1'b0;
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) spurious++;
    end
    chk("mid_no_rsp", 48'(spurious), 48'd0);
    chk("mid_done_clr", 48'(alu_done), 48'h0);

    run_op(`ALU_NOP, 48'h5, 1'b0, 1);
    chk("post_load_acc", acc, 48'h5);
    run_op(`ALU_AND, 48'h4, 1'b0, 1);
    chk("post_and_cyc", 48'(rsp_cyc), 48'd3);
    chk("post_and_err", 48'(rsp_err_s), 48'h0);
    chk("post_and_acc", acc, 48'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mesm6_alu_seq.md
MESM6_ALU_SEQ -- requirements
Module: mesm6_alu_seq

Interface
REQ-001 Parameter: TIMEOUT, 15, max ISSUE cycles waiting for alu_done before abort (range 2..15).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  sequencer accepts request this cycle.
REQ-006 req_op  in  `ALU_OP_WIDTH  ALU operation code.
REQ-007 req_operand  in  48  operand B, or load value for plain load.
REQ-008 req_wy  in  1  with `ALU_NOP: copy accumulator into ALU Y.
REQ-009 alu_op  out  `ALU_OP_WIDTH  operation driven to ALU.
REQ-010 alu_wy  out  1  Y-write strobe to ALU.
REQ-011 alu_a  out  48  accumulator, fed to ALU input A.
REQ-012 alu_b  out  48  latched operand, fed to ALU input B.
REQ-013 alu_result  in  48  ALU result.
REQ-014 alu_y  in  48  ALU least-significant-bits output.
REQ-015 alu_done  in  1  ALU finished (registered in ALU, cleared only by `ALU_NOP).
REQ-016 acc  out  48  accumulator register.
REQ-017 yreg  out  48  captured Y register.
REQ-018 rsp_valid  out  1  one-cycle completion pulse.
REQ-019 rsp_err  out  1  qualifies rsp_valid: timeout abort.

Function
REQ-020 States SHALL be IDLE, ISSUE, RELEASE, SHORT; alu_op, alu_wy, req_ready, rsp_* SHALL decode from the state register only (no input-to-output paths).
REQ-021 req_ready SHALL be 1 only in IDLE; accept = req_valid & req_ready; requests not accepted stay pending, never dropped.
REQ-022 Accept, req_op != `ALU_NOP: latch op and operand (alu_b), clear timer, IDLE -> ISSUE.
REQ-023 Accept, req_op == `ALU_NOP, req_wy=0: acc <= req_operand at accept edge, -> SHORT.
REQ-024 Accept, req_op == `ALU_NOP, req_wy=1: -> SHORT with wy flag; SHORT drives alu_wy=1, yreg <= acc at end of SHORT.
REQ-025 ISSUE: alu_op = latched op, alu_wy=0; timer increments each cycle.
REQ-026 ISSUE & alu_done: acc <= alu_result, yreg <= alu_y, -> RELEASE (rsp_err=0).
REQ-027 ISSUE & ~alu_done & timer == TIMEOUT-1: acc and yreg unchanged, -> RELEASE with error flag.
REQ-028 RELEASE and SHORT: alu_op = `ALU_NOP, rsp_valid=1 for exactly that cycle, rsp_err=error flag, then -> IDLE.
REQ-029 alu_op SHALL equal `ALU_NOP in every state except ISSUE; alu_wy SHALL be 0 except in SHORT with wy flag.
REQ-030 Every non-NOP op SHALL be followed by at least one `ALU_NOP cycle (RELEASE) before the next op, so the ALU clears done and its cycle count.
REQ-031 Latency, accept edge = cycle 0: ALU done after N ALU cycles -> rsp_valid in cycle N+2; 1-cycle op: rsp_valid cycle 3, req_ready cycle 4.
REQ-032 alu_done seen in IDLE, SHORT or RELEASE SHALL be ignored.
REQ-033 alu_a SHALL always equal acc; alu_b SHALL hold until next accept.

Reset
REQ-034 reset asserted: state IDLE, acc=0, yreg=0, alu_b=0, timer=0, error flag=0, alu_op=`ALU_NOP, alu_wy=0, rsp_valid=0, rsp_err=0, req_ready=1 (after release) -- immediately, without a clock edge.
REQ-035 Reset mid-operation SHALL abort with no response; ALU sees `ALU_NOP, clearing its done.

Verification
REQ-036 Load 0xFFFF00FF00FF (NOP, wy=0), then `ALU_AND with 0x0F0F0F0F0F0F, ALU model done after 1 cycle -> acc=0x0F0F000F000F, rsp_valid cycle 3, rsp_err=0.
REQ-037 acc=0x800000000000, `ALU_ADD_CARRY_AROUND with 0x800000000001, done after 2 cycles -> acc=0x000000000002, rsp_valid cycle 4, alu_op=`ALU_NOP cycle 4.
REQ-038 TIMEOUT=15, ALU model never asserts done -> rsp_valid=1 and rsp_err=1 in cycle 16, acc unchanged, alu_op returns to `ALU_NOP.
REQ-039 req_valid held high with back-to-back ops -> req_ready=0 in ISSUE/RELEASE, second op accepted only in IDLE, at least one NOP cycle between ops.
REQ-040 acc=0x123456789ABC, NOP with wy=1 -> alu_wy=1 for one cycle, yreg=0x123456789ABC, rsp_valid same cycle.
REQ-041 reset pulse during ISSUE -> alu_op=`ALU_NOP, acc=0 without clock edge, no rsp_valid, next request completes normally.
